vc_link_scheduler: RTL

//  Shares one physical router link between the VC+1 virtual-channel planes of a RouterPipeline.
//  - Drives the one-hot VCPlaneSelector that steers the plane muxes.
//  - Round-robin arbitration between planes that have a flit pending.
//  - Holds a plane for a whole packet (head to tail) so wormhole order is kept.
//  - With FLOW_CONTROL=1, tracks per-plane downstream credits and never sends to a plane with no credit.

---
 rtl/noc_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/vc_link_scheduler.sv | 113 +++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared types for the link scheduler: flit type encodings and scheduler states.
package noc_pkg;

  typedef enum logic [1:0] {
    HEADTAIL = 2'b00,
    HEAD     = 2'b01,
    BODY     = 2'b10,
    TAIL     = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_e;

  function automatic logic opens_packet(input logic [1:0] t);
    return (t == HEAD) || (t == HEADTAIL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_link_scheduler.sv
// Shares one router link between VC+1 virtual-channel planes: round-robin packet
// arbitration, wormhole lock from head to tail, optional per-plane credit gating.
module vc_link_scheduler
  import noc_pkg::*;
#(
  parameter int VC           = 4,
  parameter int TYPE_WIDTH   = 2,
  parameter int FIFO_DEPTH   = 32,
  parameter int FLOW_CONTROL = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [VC:0]                plane_valid,
  input  logic [VC:0][TYPE_WIDTH-1:0] plane_type,
  output logic [VC:0]                plane_ready,
  output logic                       link_valid,
  input  logic                       link_ready,
  input  logic [VC:0]                credit_return,
  output logic [VC:0]                VCPlaneSelector,
  output logic                       locked,
  output logic                       proto_err
);

  localparam int N  = VC + 1;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  sched_state_e  state, state_nxt;
  logic [PW-1:0] rr_ptr, lock_id, gnt_id, sel_id;
  logic [N-1:0]  credit_ok, credit_over, eligible, stray, gnt;
  logic [1:0]    sel_type;
  logic          xfer, err_now;

  for (genvar i = 0; i < N; i++) begin : g_plane
    logic [CW-1:0] credit;
    logic          inc, dec;

    assign inc = credit_return[i];
    assign dec = plane_ready[i];

    // A return and a send in the same cycle cancel; increments saturate at full depth.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                            credit <= CW'(FIFO_DEPTH);
      else if (inc && !dec && credit != CW'(FIFO_DEPTH))   credit <= credit + CW'(1);
      else if (dec && !inc)                                credit <= credit - CW'(1);
    end

    assign credit_ok[i]   = (FLOW_CONTROL == 0) || (credit != '0);
    assign credit_over[i] = (FLOW_CONTROL != 0) && inc && !dec && (credit == CW'(FIFO_DEPTH));
    assign eligible[i]    = plane_valid[i] && credit_ok[i] && opens_packet(plane_type[i][1:0]);
    assign stray[i]       = plane_valid[i] && !opens_packet(plane_type[i][1:0]);
  end

  rr_arbiter #(.N(N), .PW(PW)) u_arb (
    .req (eligible),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < N; i++) if (gnt[i]) gnt_id = PW'(i);
  end

  always_comb begin
    state_nxt       = state;
    VCPlaneSelector = '0;
    link_valid      = 1'b0;
    sel_id          = lock_id;
    if (state == IDLE) begin
      VCPlaneSelector = gnt;
      link_valid      = |gnt;
      sel_id          = gnt_id;
    end else begin
      VCPlaneSelector[lock_id] = 1'b1;
      link_valid               = plane_valid[lock_id];
    end
    // Grant outputs are forced idle while reset is held.
    if (!rst) begin
      VCPlaneSelector = '0;
      link_valid      = 1'b0;
    end
    sel_type = plane_type[sel_id][1:0];
    xfer     = link_valid && link_ready && credit_ok[sel_id];
    if (xfer) begin
      if (state == IDLE && sel_type == HEAD)        state_nxt = LOCKED;
      else if (state == LOCKED && sel_type == TAIL) state_nxt = IDLE;
    end
    plane_ready = VCPlaneSelector & {N{xfer}};
  end

  assign err_now = ((state == IDLE) && (|stray)) ||
                   ((state == LOCKED) && xfer && opens_packet(sel_type)) ||
                   (|credit_over);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= PW'(VC);
      lock_id   <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer && state == IDLE && sel_type == HEAD)      lock_id <= sel_id;
      if (xfer && state == IDLE && sel_type == HEADTAIL)  rr_ptr  <= sel_id;
      if (xfer && state == LOCKED && sel_type == TAIL)    rr_ptr  <= lock_id;
      if (err_now)                                        proto_err <= 1'b1;
    end
  end

  assign locked = (state == LOCKED);

endmodule
